// File: rtl/mem_ram_slave.sv
// Word-organised RAM slave on the PicoRV32 native memory interface (mem_valid/mem_ready).
// Latency: mem_valid first seen in cycle k -> one-cycle mem_ready pulse in cycle k+1+WAIT_STATES.
// Backpressure: a request is latched at accept; bus inputs are ignored until the response pulse ends.
//
// Ports: clk, reset (async, active-high); mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb in;
//        mem_ready/mem_rdata/bus_err out.
// Optional feature macro: MEM_RAM_BUS_ERR_EN -- out-of-range accesses return 32'hDEADBEEF, drop
//        writes and set the sticky bus_err flag. Without it, addresses wrap modulo DEPTH_WORDS.
module mem_ram_slave #(
    parameter int          DEPTH_WORDS = 4096,          // power of two, >= 2
    parameter int          WAIT_STATES = 1,             // 0..15
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000  // 4-byte aligned
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        bus_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          oor_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   sel_addr;
    logic [31:0]   addr_off;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          enter_resp;
    logic          unused_bits;

    // With zero wait states the read happens on the accept edge itself, so the
    // decode must look at the live bus address while idle and the latched one otherwise.
    assign sel_addr = (state == S_IDLE) ? mem_addr : addr_q;
    assign addr_off = sel_addr - BASE_ADDR;
    assign idx      = addr_off[AW+1:2];

`ifdef MEM_RAM_BUS_ERR_EN
    // 33-bit compare so a window ending at 4 GiB does not wrap.
    logic [32:0] span_end;
    assign span_end = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    assign in_range = ({1'b0, sel_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, sel_addr} < span_end);
`else
    assign in_range = 1'b1;
`endif

    assign enter_resp = ((state == S_IDLE) && mem_valid && (WAIT_STATES == 0)) ||
                        ((state == S_WAIT) && (cnt == 4'd1));

    assign mem_ready = (state == S_RESP);

    // mem_instr and the byte-offset / high offset bits do not affect behaviour.
    assign unused_bits = ^{mem_instr, addr_off[1:0], addr_off[31:AW+2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            oor_q     <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_valid) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        oor_q   <= !in_range;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // Read data is captured on entry to RESP; on a write this is the pre-write word.
            if (enter_resp) begin
                mem_rdata <= in_range ? mem[idx] : 32'hDEAD_BEEF;
            end
        end
    end

`ifdef MEM_RAM_BUS_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if ((state == S_RESP) && oor_q) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

    // Storage is not reset. The write commits on the edge that ends RESP, so a
    // reset arriving earlier in the transaction leaves the word untouched.
    always_ff @(posedge clk) begin
        if ((state == S_RESP) && (wstrb_q != 4'd0) && !oor_q && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule
